// File: rtl/stepper_pkg.sv
// Shared types, phase tables and the coil lookup for the stepper sequencer.
// Define STEPPER_HALF_STEP_EN to select the 8-entry half-step table.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entry 0 sits in the least significant nibble.
  localparam logic [15:0] FULL_STEP_TABLE = 16'b1001_0011_0110_1100;
  localparam logic [31:0] HALF_STEP_TABLE = 32'b1001_0001_0011_0010_0110_0100_1100_1000;

`ifdef STEPPER_HALF_STEP_EN
  localparam int PHASE_N = 8;
  localparam int PHASE_W = 3;
`else
  localparam int PHASE_N = 4;
  localparam int PHASE_W = 2;
`endif

  function automatic logic [3:0] phase_coil(input logic [PHASE_W-1:0] idx);
`ifdef STEPPER_HALF_STEP_EN
    phase_coil = HALF_STEP_TABLE[{idx, 2'b00} +: 4];
`else
    phase_coil = FULL_STEP_TABLE[{idx, 2'b00} +: 4];
`endif
  endfunction

endpackage

// File: rtl/stepper_sequencer_step_timer.sv
// Free-running step divider: counts 0..STEP_DIV-1 and flags the terminal count.
module step_timer #(
  parameter int STEP_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] count_r;

  assign tick = (count_r == TERM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear || tick) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stepper_sequencer.sv
// Command-driven stepper sequencer: valid/ready move commands, paced coil phases,
// signed position tracking. STEPPER_HALF_STEP_EN selects the half-step table.
module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int STEP_DIV = 50000,
  parameter int COUNT_W  = 16,
  parameter int POS_W    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_dir,
  input  logic [COUNT_W-1:0]       cmd_steps,
  input  logic                     abort,
  input  logic                     hold,
  output logic [3:0]               coil,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic signed [POS_W-1:0]  pos
);

  state_t               state_r;
  state_t               state_next_s;
  logic [COUNT_W-1:0]   remaining_r;
  logic                 dir_r;
  logic [PHASE_W-1:0]   phase_r;
  logic [PHASE_W-1:0]   phase_next_s;
  logic                 accept_s;
  logic                 abort_s;
  logic                 step_s;
  logic                 tick_s;
  logic                 timer_clear_s;
  logic                 ready_next_s;
  logic                 busy_next_s;
  logic                 done_next_s;
  logic [3:0]           coil_next_s;

  assign accept_s      = (state_r == IDLE) && cmd_valid;
  assign abort_s       = (state_r == RUN) && abort;
  // Abort wins over a coinciding terminal count: no step on the abort edge.
  assign step_s        = (state_r == RUN) && !abort && tick_s;
  assign timer_clear_s = accept_s || abort_s;

  step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clear_s),
    .tick  (tick_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = (cmd_steps == COUNT_W'(0)) ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_next_s = DONE;
        end else if (tick_s && (remaining_r == COUNT_W'(1))) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  always_comb begin
    phase_next_s = phase_r;
    if (step_s) begin
      phase_next_s = dir_r ? (phase_r + PHASE_W'(1)) : (phase_r - PHASE_W'(1));
    end else begin
      phase_next_s = phase_r;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      remaining_r <= {COUNT_W{1'b0}};
      dir_r       <= 1'b0;
      phase_r     <= {PHASE_W{1'b0}};
      pos         <= {POS_W{1'b0}};
      aborted     <= 1'b0;
    end else if (accept_s) begin
      dir_r       <= cmd_dir;
      remaining_r <= cmd_steps;
      aborted     <= 1'b0;
    end else if (abort_s) begin
      aborted     <= 1'b1;
    end else if (step_s) begin
      remaining_r <= remaining_r - COUNT_W'(1);
      phase_r     <= phase_next_s;
      pos         <= dir_r ? (pos + POS_W'(1)) : (pos - POS_W'(1));
    end
  end

  // Output values are decoded from the next state so the registers line up with it.
  always_comb begin
    ready_next_s = 1'b0;
    busy_next_s  = 1'b0;
    done_next_s  = 1'b0;
    coil_next_s  = 4'b0000;
    case (state_next_s)
      IDLE: begin
        ready_next_s = 1'b1;
        if (hold) begin
          coil_next_s = phase_coil(phase_next_s);
        end else begin
          coil_next_s = 4'b0000;
        end
      end
      RUN: begin
        busy_next_s = 1'b1;
        coil_next_s = phase_coil(phase_next_s);
      end
      DONE: begin
        busy_next_s = 1'b1;
        done_next_s = 1'b1;
        coil_next_s = phase_coil(phase_next_s);
      end
      default: begin
        ready_next_s = 1'b1;
        coil_next_s  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      coil      <= 4'b0000;
    end else begin
      cmd_ready <= ready_next_s;
      busy      <= busy_next_s;
      done      <= done_next_s;
      coil      <= coil_next_s;
    end
  end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Self-checking bench for stepper_sequencer with STEP_DIV=4; expectations come from
// a closed-form timeline model (steps taken = elapsed cycles / STEP_DIV).
module tb_stepper_sequencer;

  localparam int SD = 4;

`ifdef STEPPER_HALF_STEP_EN
  localparam int P = 8;
  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
  localparam int P = 4;
  logic [3:0] tbl [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic        abort;
  logic        hold;
  logic [3:0]  coil;
  logic        busy;
  logic        done;
  logic        aborted;
  logic signed [31:0] pos;

  int total = 0;
  int bad   = 0;
  int mpos  = 0;
  int mph   = 0;

  stepper_sequencer #(
    .STEP_DIV (SD),
    .COUNT_W  (16),
    .POS_W    (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .hold      (hold),
    .coil      (coil),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .pos       (pos)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

  function automatic int wrap_phase(input int x);
    return ((x % P) + P) % P;
  endfunction

  // Offer one command and follow it cycle by cycle until the sequencer is idle again.
  task automatic do_move(input bit dir, input int n, input int abort_at, input bit hld,
                         input bit keep_valid);
    int sign, endt, nsteps, k, eph, epos;
    bit ab, e_ready, e_busy, e_done, e_ab;
    logic [3:0] e_coil;
    sign = dir ? 1 : -1;
    if (n > 0 && abort_at >= 1 && abort_at <= n * SD) begin
      endt = abort_at; nsteps = (abort_at - 1) / SD; ab = 1'b1;
    end else begin
      endt = n * SD; nsteps = n; ab = 1'b0;
    end
    hold = hld; cmd_dir = dir; cmd_steps = 16'(n); cmd_valid = 1'b1; abort = 1'b0;
    @(posedge clock); #1;
    if (!keep_valid) cmd_valid = 1'b0;
    for (int t = 0; t <= endt + 1; t++) begin
      if (t > 0) begin @(posedge clock); #1; end
      k       = (t < endt) ? t / SD : nsteps;
      eph     = wrap_phase(mph + sign * k);
      epos    = mpos + sign * k;
      e_ready = (t == endt + 1);
      e_busy  = !e_ready;
      e_done  = (t == endt);
      e_ab    = (t >= endt) ? ab : 1'b0;
      e_coil  = (e_busy || hld) ? tbl[eph] : 4'b0000;
      total++;
      if (coil !== e_coil) begin
        bad++; $display("FAIL coil t=%0d n=%0d: got %b expected %b", t, n, coil, e_coil);
      end
      total++;
      if (pos !== 32'(epos)) begin
        bad++; $display("FAIL pos t=%0d n=%0d: got %0d expected %0d", t, n, pos, epos);
      end
      total++;
      if ({cmd_ready, busy, done, aborted} !== {e_ready, e_busy, e_done, e_ab}) begin
        bad++;
        $display("FAIL status t=%0d n=%0d: got rdy/busy/done/ab=%b%b%b%b expected %b%b%b%b",
                 t, n, cmd_ready, busy, done, aborted, e_ready, e_busy, e_done, e_ab);
      end
      abort = (abort_at >= 1 && t == abort_at - 1) ? 1'b1 : 1'b0;
    end
    abort = 1'b0;
    mph  = wrap_phase(mph + sign * nsteps);
    mpos = mpos + sign * nsteps;
  endtask

  task automatic test_reset;
    reset = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = 16'd0;
    abort = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    mpos = 0; mph = 0;
    total++;
    if ({cmd_ready, busy, done, aborted, coil} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_state: got rdy/busy/done/ab/coil=%b%b%b%b/%b expected 1000/0000",
               cmd_ready, busy, done, aborted, coil);
    end
    total++;
    if (pos !== 32'sd0) begin
      bad++; $display("FAIL reset_pos: got %0d expected 0", pos);
    end
  endtask

  task automatic test_forward;
    do_move(1'b1, 3, 0, 1'b0, 1'b0);
    total++;
    if (pos !== 32'sd3) begin
      bad++; $display("FAIL forward_pos: got %0d expected 3", pos);
    end
  endtask

  task automatic test_reverse;
    do_move(1'b0, 5, 0, 1'b1, 1'b0);
    total++;
    if (pos !== -32'sd2) begin
      bad++; $display("FAIL reverse_pos: got %0d expected -2", pos);
    end
  endtask

  task automatic test_zero_steps;
    do_move(1'b1, 0, 0, 1'b1, 1'b1);
    do_move(1'b1, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_abort;
    do_move(1'b1, 10, 6, 1'b0, 1'b0);
    total++;
    if (aborted !== 1'b1) begin
      bad++; $display("FAIL abort_sticky: got %b expected 1", aborted);
    end
    do_move(1'b0, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_move;
    hold = 1'b0; cmd_dir = 1'b1; cmd_steps = 16'd10; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    total++;
    if ({cmd_ready, busy, done, aborted, coil} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000} ||
        pos !== 32'sd0) begin
      bad++;
      $display("FAIL reset_mid_move: got rdy/busy/done/ab/coil/pos=%b%b%b%b/%b/%0d expected 1000/0000/0",
               cmd_ready, busy, done, aborted, coil, pos);
    end
    @(negedge clock) reset = 1'b1;
    mpos = 0; mph = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      total++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++; $display("FAIL post_reset_idle: got done=%b rdy=%b expected done=0 rdy=1",
                        done, cmd_ready);
      end
    end
  endtask

  task automatic test_table_walk;
    do_move(1'b1, 9, 0, 1'b1, 1'b0);
    total++;
    if (pos !== 32'sd9 || coil !== tbl[1]) begin
      bad++; $display("FAIL table_walk: got pos=%0d coil=%b expected 9/%b", pos, coil, tbl[1]);
    end
  endtask

  task automatic test_random;
    int n, ab_at;
    for (int i = 0; i < 10; i++) begin
      n = int'($urandom_range(0, 12));
      ab_at = 0;
      if (n > 0 && $urandom_range(0, 3) == 0) ab_at = int'($urandom_range(1, n * SD + 2));
      do_move(1'($urandom_range(0, 1)), n, ab_at, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_forward;
    test_reverse;
    test_zero_steps;
    test_abort;
    test_reset_mid_move;
    test_table_walk;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
